// File: rtl/eeprom_arbiter_if.sv
// rtl/eeprom_arbiter_if.sv - client and engine signal bundle for eeprom_arbiter
interface eeprom_arbiter_if #(
    parameter int AW = 11,
    parameter int DW = 8
);
    logic          c0_req;
    logic          c1_req;
    logic          c0_we;
    logic          c1_we;
    logic [AW-1:0] c0_addr;
    logic [AW-1:0] c1_addr;
    logic [DW-1:0] c0_wdata;
    logic [DW-1:0] c1_wdata;
    logic          c0_gnt;
    logic          c1_gnt;
    logic          c0_done;
    logic          c1_done;
    logic          c0_err;
    logic          c1_err;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          eng_wr;
    logic          eng_rd;
    logic [AW-1:0] eng_addr;
    logic [DW-1:0] eng_wdata;
    logic [DW-1:0] eng_rdata;
    logic          eng_ack;

    // Clients and engine model drive the request side and the engine response.
    modport master (
        output c0_req, c1_req, c0_we, c1_we, c0_addr, c1_addr, c0_wdata, c1_wdata,
        output eng_rdata, eng_ack,
        input  c0_gnt, c1_gnt, c0_done, c1_done, c0_err, c1_err, rd_data, busy,
        input  eng_wr, eng_rd, eng_addr, eng_wdata
    );

    // The arbiter consumes requests and engine responses, drives everything else.
    modport slave (
        input  c0_req, c1_req, c0_we, c1_we, c0_addr, c1_addr, c0_wdata, c1_wdata,
        input  eng_rdata, eng_ack,
        output c0_gnt, c1_gnt, c0_done, c1_done, c0_err, c1_err, rd_data, busy,
        output eng_wr, eng_rd, eng_addr, eng_wdata
    );
endinterface

// File: rtl/eeprom_arbiter.sv
// rtl/eeprom_arbiter.sv - two-client round-robin arbiter for the I2C EEPROM engine (option: EEPROM_ARB_TIMEOUT_EN)
module eeprom_arbiter #(
    parameter int AW             = 11,
    parameter int DW             = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic           CLK,
    input  logic           RESET,
    eeprom_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state, state_nxt;
    logic          win_q, win_nxt;      // 0 = client 0 owns the transaction
    logic          last_q, last_nxt;    // client served most recently
    logic          we_q, we_nxt;
    logic [AW-1:0] addr_q, addr_nxt;
    logic [DW-1:0] wdata_q, wdata_nxt;
    logic [DW-1:0] rd_data_q, rd_data_nxt;
    logic          gnt0_q, gnt0_nxt, gnt1_q, gnt1_nxt;
    logic          done0_q, done0_nxt, done1_q, done1_nxt;
    logic          wr_q, wr_nxt, rd_q, rd_nxt;
    logic          busy_q, busy_nxt;
    logic          pick1;

`ifdef EEPROM_ARB_TIMEOUT_EN
    localparam logic [12:0] TO_LAST = 13'(TIMEOUT_CYCLES - 1);
    logic [12:0] wait_cnt;
    logic        err0_q, err0_nxt, err1_q, err1_nxt;
`endif

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus next value of every registered output; outputs are
    // computed for the state being entered so they appear in that state's cycle.
    always_comb begin
        state_nxt   = state;
        win_nxt     = win_q;
        last_nxt    = last_q;
        we_nxt      = we_q;
        addr_nxt    = addr_q;
        wdata_nxt   = wdata_q;
        rd_data_nxt = rd_data_q;
        gnt0_nxt    = 1'b0;
        gnt1_nxt    = 1'b0;
        done0_nxt   = 1'b0;
        done1_nxt   = 1'b0;
        wr_nxt      = 1'b0;
        rd_nxt      = 1'b0;
        pick1       = 1'b0;
`ifdef EEPROM_ARB_TIMEOUT_EN
        err0_nxt    = 1'b0;
        err1_nxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.c0_req || bus.c1_req) begin
                    // Client 1 wins alone, or on a tie when client 0 was served last.
                    pick1     = bus.c1_req && (!bus.c0_req || !last_q);
                    win_nxt   = pick1;
                    we_nxt    = pick1 ? bus.c1_we    : bus.c0_we;
                    addr_nxt  = pick1 ? bus.c1_addr  : bus.c0_addr;
                    wdata_nxt = pick1 ? bus.c1_wdata : bus.c0_wdata;
                    gnt0_nxt  = !pick1;
                    gnt1_nxt  = pick1;
                    wr_nxt    = we_nxt;
                    rd_nxt    = !we_nxt;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.eng_ack) begin
                    if (!we_q) begin
                        rd_data_nxt = bus.eng_rdata;
                    end
                    done0_nxt = !win_q;
                    done1_nxt = win_q;
                    state_nxt = DONE;
                end
`ifdef EEPROM_ARB_TIMEOUT_EN
                else if (wait_cnt == TO_LAST) begin
                    done0_nxt = !win_q;
                    done1_nxt = win_q;
                    err0_nxt  = !win_q;
                    err1_nxt  = win_q;
                    state_nxt = DONE;
                end
`endif
            end
            DONE: begin
                last_nxt  = win_q;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // Transaction fields and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            win_q     <= 1'b0;
            last_q    <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            win_q     <= win_nxt;
            last_q    <= last_nxt;
            we_q      <= we_nxt;
            addr_q    <= addr_nxt;
            wdata_q   <= wdata_nxt;
            rd_data_q <= rd_data_nxt;
            gnt0_q    <= gnt0_nxt;
            gnt1_q    <= gnt1_nxt;
            done0_q   <= done0_nxt;
            done1_q   <= done1_nxt;
            wr_q      <= wr_nxt;
            rd_q      <= rd_nxt;
            busy_q    <= busy_nxt;
        end
    end

`ifdef EEPROM_ARB_TIMEOUT_EN
    // WAIT cycle counter: zeroed while issuing, counts every cycle spent in WAIT.
    always_ff @(posedge CLK) begin
        if (RESET || state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 13'd1;
        end
    end

    // Error pulses travel alongside the done pulse.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            err0_q <= 1'b0;
            err1_q <= 1'b0;
        end else begin
            err0_q <= err0_nxt;
            err1_q <= err1_nxt;
        end
    end

    assign bus.c0_err = err0_q;
    assign bus.c1_err = err1_q;
`else
    assign bus.c0_err = 1'b0;
    assign bus.c1_err = 1'b0;
`endif

    assign bus.c0_gnt    = gnt0_q;
    assign bus.c1_gnt    = gnt1_q;
    assign bus.c0_done   = done0_q;
    assign bus.c1_done   = done1_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.busy      = busy_q;
    assign bus.eng_wr    = wr_q;
    assign bus.eng_rd    = rd_q;
    assign bus.eng_addr  = addr_q;
    assign bus.eng_wdata = wdata_q;

endmodule

// File: tb/tb_eeprom_arbiter.sv
// tb/tb_eeprom_arbiter.sv - self-checking bench for eeprom_arbiter
module tb_eeprom_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    eeprom_arbiter_if #(.AW(11), .DW(8)) bus ();

    eeprom_arbiter #(.AW(11), .DW(8), .TIMEOUT_CYCLES(16)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    typedef struct {
        logic       client;
        logic       we;
        logic [10:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         lat;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_c0_gnt"},  32'(bus.c0_gnt),  0);
        chk({tag, "_c1_gnt"},  32'(bus.c1_gnt),  0);
        chk({tag, "_c0_done"}, 32'(bus.c0_done), 0);
        chk({tag, "_c1_done"}, 32'(bus.c1_done), 0);
        chk({tag, "_c0_err"},  32'(bus.c0_err),  0);
        chk({tag, "_c1_err"},  32'(bus.c1_err),  0);
        chk({tag, "_busy"},    32'(bus.busy),    0);
        chk({tag, "_eng_wr"},  32'(bus.eng_wr),  0);
        chk({tag, "_eng_rd"},  32'(bus.eng_rd),  0);
        chk({tag, "_eng_addr"},  32'(bus.eng_addr),  0);
        chk({tag, "_eng_wdata"}, 32'(bus.eng_wdata), 0);
        chk({tag, "_rd_data"},   32'(bus.rd_data),   0);
    endtask

    task automatic set_req(input logic client, input logic we, input logic [10:0] addr, input logic [7:0] wdata);
        if (client) begin
            bus.c1_req = 1'b1; bus.c1_we = we; bus.c1_addr = addr; bus.c1_wdata = wdata;
        end else begin
            bus.c0_req = 1'b1; bus.c0_we = we; bus.c0_addr = addr; bus.c0_wdata = wdata;
        end
    endtask

    // Runs one single-client transaction starting from a negedge in IDLE.
    task automatic do_txn(input int idx, input vec_t v);
        string p;
        p = $sformatf("v%0d", idx);
        set_req(v.client, v.we, v.addr, v.wdata);
        @(negedge clk);
        chk({p, "_c0_gnt"},    32'(bus.c0_gnt),    32'(!v.client));
        chk({p, "_c1_gnt"},    32'(bus.c1_gnt),    32'(v.client));
        chk({p, "_eng_wr"},    32'(bus.eng_wr),    32'(v.we));
        chk({p, "_eng_rd"},    32'(bus.eng_rd),    32'(!v.we));
        chk({p, "_eng_addr"},  32'(bus.eng_addr),  32'(v.addr));
        chk({p, "_eng_wdata"}, 32'(bus.eng_wdata), 32'(v.wdata));
        chk({p, "_busy"},      32'(bus.busy),      1);
        bus.c0_req = 1'b0;
        bus.c1_req = 1'b0;
        @(negedge clk);
        chk({p, "_strobe_off"}, 32'(bus.eng_wr | bus.eng_rd | bus.c0_gnt | bus.c1_gnt), 0);
        repeat (v.lat - 1) @(negedge clk);
        bus.eng_rdata = v.rdata;
        bus.eng_ack   = 1'b1;
        @(negedge clk);
        bus.eng_ack   = 1'b0;
        chk({p, "_c0_done"},  32'(bus.c0_done),  32'(!v.client));
        chk({p, "_c1_done"},  32'(bus.c1_done),  32'(v.client));
        chk({p, "_err"},      32'(bus.c0_err | bus.c1_err), 0);
        chk({p, "_rd_data"},  32'(bus.rd_data),  32'(v.exp_rd));
        chk({p, "_addr_hold"}, 32'(bus.eng_addr), 32'(v.addr));
        @(negedge clk);
        chk({p, "_idle_done"}, 32'(bus.c0_done | bus.c1_done), 0);
        chk({p, "_idle_busy"}, 32'(bus.busy), 0);
    endtask

    // Waits up to 10 negedges for a grant; who = -1 if none arrived.
    task automatic wait_gnt(output int who, output int n);
        who = -1;
        n   = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (bus.c0_gnt) begin who = 0; break; end
            if (bus.c1_gnt) begin who = 1; break; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int who;
        int n;
        int w;

        vecs[0] = '{1'b0, 1'b1, 11'h123, 8'hA5, 8'hEE, 3, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 11'h7FF, 8'h00, 8'h3C, 2, 8'h3C};
        vecs[2] = '{1'b0, 1'b1, 11'h0FF, 8'h5A, 8'h99, 1, 8'h3C};
        vecs[3] = '{1'b0, 1'b0, 11'h400, 8'h00, 8'hC3, 1, 8'hC3};
        vecs[4] = '{1'b1, 1'b1, 11'h001, 8'hFF, 8'h12, 4, 8'hC3};
        vecs[5] = '{1'b1, 1'b0, 11'h000, 8'h00, 8'h00, 2, 8'h00};

        rst = 1'b1;
        bus.c0_req = 1'b0; bus.c1_req = 1'b0;
        bus.c0_we = 1'b0;  bus.c1_we = 1'b0;
        bus.c0_addr = '0;  bus.c1_addr = '0;
        bus.c0_wdata = '0; bus.c1_wdata = '0;
        bus.eng_rdata = '0; bus.eng_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            do_txn(i, vecs[i]);
        end

        // Both clients hold req: grants must alternate, starting with c0.
        set_req(1'b0, 1'b1, 11'h010, 8'h11);
        set_req(1'b1, 1'b0, 11'h020, 8'h22);
        for (int g = 0; g < 4; g++) begin
            wait_gnt(who, n);
            chk($sformatf("rr%0d_who", g), 32'(who), 32'(g % 2));
            chk($sformatf("rr%0d_gap", g), 32'(n), (g == 0) ? 1 : 2);
            chk($sformatf("rr%0d_addr", g), 32'(bus.eng_addr), (g % 2 == 1) ? 32'h020 : 32'h010);
            if (g == 3) begin
                bus.c0_req = 1'b0;
                bus.c1_req = 1'b0;
            end
            @(negedge clk);
            bus.eng_rdata = 8'h5E;
            bus.eng_ack   = 1'b1;
            @(negedge clk);
            bus.eng_ack   = 1'b0;
            chk($sformatf("rr%0d_done", g),
                32'({bus.c1_done, bus.c0_done}), (g % 2 == 1) ? 32'd2 : 32'd1);
        end
        @(negedge clk);
        chk("rr_rd_data", 32'(bus.rd_data), 32'h5E);

        // Ack in IDLE and in ISSUE must be ignored.
        bus.eng_ack = 1'b1;
        repeat (2) @(negedge clk);
        chk("ack_idle_busy", 32'(bus.busy), 0);
        chk("ack_idle_done", 32'(bus.c0_done | bus.c1_done), 0);
        set_req(1'b0, 1'b0, 11'h155, 8'h00);
        @(negedge clk);
        chk("ack_issue_gnt", 32'(bus.c0_gnt), 1);
        chk("ack_issue_rd",  32'(bus.eng_rd), 1);
        bus.c0_req = 1'b0;
        @(negedge clk);
        bus.eng_ack = 1'b0;
        chk("ack_wait_done", 32'(bus.c0_done), 0);
        repeat (3) @(negedge clk);
        chk("ack_still_busy", 32'(bus.busy), 1);
        chk("ack_still_nodone", 32'(bus.c0_done), 0);
        bus.eng_rdata = 8'h77;
        bus.eng_ack   = 1'b1;
        @(negedge clk);
        bus.eng_ack   = 1'b0;
        chk("ack_real_done", 32'(bus.c0_done), 1);
        chk("ack_real_rd",   32'(bus.rd_data), 32'h77);
        @(negedge clk);

`ifdef EEPROM_ARB_TIMEOUT_EN
        // No ack: DONE with err after 16 WAIT cycles, rd_data untouched.
        set_req(1'b0, 1'b0, 11'h2AA, 8'h00);
        @(negedge clk);
        chk("to_gnt", 32'(bus.c0_gnt), 1);
        bus.c0_req = 1'b0;
        w = 0;
        while (w < 40) begin
            @(negedge clk);
            if (bus.c0_done) break;
            w++;
        end
        chk("to_wait_cycles", 32'(w), 16);
        chk("to_done", 32'(bus.c0_done), 1);
        chk("to_err",  32'(bus.c0_err), 1);
        chk("to_rd_keep", 32'(bus.rd_data), 32'h77);
        @(negedge clk);
        chk("to_err_pulse", 32'(bus.c0_err), 0);

        // Ack on the 16th WAIT cycle beats the timeout.
        set_req(1'b0, 1'b0, 11'h2AB, 8'h00);
        @(negedge clk);
        bus.c0_req = 1'b0;
        repeat (16) @(negedge clk);
        chk("to16_nodone", 32'(bus.c0_done), 0);
        bus.eng_rdata = 8'hE1;
        bus.eng_ack   = 1'b1;
        @(negedge clk);
        bus.eng_ack   = 1'b0;
        chk("to16_done", 32'(bus.c0_done), 1);
        chk("to16_err",  32'(bus.c0_err), 0);
        chk("to16_rd",   32'(bus.rd_data), 32'hE1);
        @(negedge clk);
`else
        // Without the timeout option WAIT lasts until ack arrives.
        set_req(1'b0, 1'b0, 11'h2AA, 8'h00);
        @(negedge clk);
        bus.c0_req = 1'b0;
        w = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.c0_done || bus.c0_err) w++;
        end
        chk("long_wait_nodone", 32'(w), 0);
        chk("long_wait_busy", 32'(bus.busy), 1);
        bus.eng_rdata = 8'hE1;
        bus.eng_ack   = 1'b1;
        @(negedge clk);
        bus.eng_ack   = 1'b0;
        chk("long_wait_done", 32'(bus.c0_done), 1);
        chk("long_wait_err",  32'(bus.c0_err), 0);
        chk("long_wait_rd",   32'(bus.rd_data), 32'hE1);
        @(negedge clk);
`endif

        // Reset during WAIT of a c1 read (c0 was served last).
        set_req(1'b1, 1'b0, 11'h7FF, 8'h00);
        @(negedge clk);
        chk("rst_c1_gnt", 32'(bus.c1_gnt), 1);
        bus.c1_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("midrst");
        bus.eng_rdata = 8'h99;
        repeat (2) @(negedge clk);
        chk("midrst_no_c1_done", 32'(bus.c1_done), 0);
        chk("midrst_idle", 32'(bus.busy), 0);
        set_req(1'b0, 1'b1, 11'h011, 8'h33);
        set_req(1'b1, 1'b1, 11'h022, 8'h44);
        @(negedge clk);
        chk("midrst_c0_gnt", 32'(bus.c0_gnt), 1);
        chk("midrst_c1_gnt", 32'(bus.c1_gnt), 0);
        bus.c0_req = 1'b0;
        bus.c1_req = 1'b0;
        @(negedge clk);
        bus.eng_ack = 1'b1;
        @(negedge clk);
        bus.eng_ack = 1'b0;
        chk("midrst_c0_done", 32'(bus.c0_done), 1);
        chk("midrst_rd_keep", 32'(bus.rd_data), 0);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eeprom_arbiter.md
# eeprom_arbiter

Two-client request arbiter and sequencer for the shared I2C EEPROM read/write engine. It accepts byte read and byte write requests from two independent clients. It grants one request at a time using round-robin priority and issues a single-cycle WR or RD strobe to the engine. It then waits for the engine's end-of-transaction ACK and returns read data and completion status to the granted client. It sits between system-side masters and the engine; the top level ties `eng_wdata`/`eng_rdata` onto the engine's bidirectional DATA bus.

## Interface
Parameters:
- `AW`, 11, byte address width; matches the engine's ADDR[10:0], where bits [10:8] form the block select.
- `DW`, 8, data width.
- `TIMEOUT_CYCLES`, 4096, number of WAIT cycles before a transaction is abandoned. Used only with `EEPROM_ARB_TIMEOUT_EN`.

Ports:
- `CLK` in 1: clock. All logic is rising-edge.
- `RESET` in 1: reset, synchronous, active-high.
- `c0_req`, `c1_req` in 1: request level, held by the client until its grant.
- `c0_we`, `c1_we` in 1: 1 requests a write, 0 requests a read.
- `c0_addr`, `c1_addr` in AW: byte address.
- `c0_wdata`, `c1_wdata` in DW: write data.
- `c0_gnt`, `c1_gnt` out 1: one-cycle pulse; the request has been accepted and latched.
- `c0_done`, `c1_done` out 1: one-cycle completion pulse.
- `c0_err`, `c1_err` out 1: one-cycle pulse, coincident with done, on timeout.
- `rd_data` out DW: read result. Valid while done is high; holds its value otherwise.
- `busy` out 1: high whenever state ≠ IDLE.
- `eng_wr`, `eng_rd` out 1: engine strobes, mutually exclusive.
- `eng_addr` out AW, `eng_wdata` out DW: latched transaction fields.
- `eng_rdata` in DW: engine read data, sampled on ACK.
- `eng_ack` in 1: engine end-of-transaction pulse.

## Operation
- FSM states: IDLE → ISSUE → WAIT → DONE → IDLE. All outputs are registered.
- IDLE:
  - If any req is high, select the winner.
  - With both requesting, the client not served last wins.
  - After reset, client 0 wins the first tie.
  - Latch the winner's we/addr/wdata and the winner id.
  - Next state is ISSUE.
- ISSUE:
  - `cN_gnt` is high for this cycle only.
  - `eng_wr` is high if we=1, otherwise `eng_rd`, for exactly this one cycle.
  - Next state is WAIT.
- WAIT:
  - Strobes are low.
  - When `eng_ack` is sampled high: if the transaction is a read, capture `eng_rdata` into `rd_data`. Next state is DONE.
- DONE:
  - `cN_done` is high for one cycle.
  - The last-served pointer updates to the winner.
  - Next state is IDLE.
- `eng_addr`/`eng_wdata` are stable from ISSUE through DONE and hold their values in IDLE.
- Write transactions leave `rd_data` unchanged.
- `eng_ack` is ignored outside WAIT.
- A request that is still high after done is treated as a new request and re-arbitrated.
- The address passes through unmodified. No width conversion occurs.
- Reset mid-transaction aborts immediately: no done or err is issued, and the pending client must re-request.

## Timing
- Reset values:
  - All outputs are 0: gnt, done, err, busy, eng_wr, eng_rd, eng_addr, eng_wdata, rd_data.
  - State is IDLE and the pointer is "last = client 1".
- With req sampled at edge 0:
  - gnt and strobe are high in cycle 1.
  - WAIT begins in cycle 2.
- With ack sampled at edge k:
  - done and `rd_data` are valid in cycle k+1.
  - IDLE is reached in cycle k+2.
  - The earliest next grant is cycle k+3.
- Minimum turnaround is 4 cycles plus the engine latency.
- A single requester is never starved. A requester that holds req is served within one other transaction.

## Configuration
- `EEPROM_ARB_TIMEOUT_EN` defined:
  - A 13-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` with no ack, go to DONE with `cN_err`=1 and `rd_data` unchanged.
  - If ack arrives in the same cycle the count reaches the limit, ack wins and err=0.
- `EEPROM_ARB_TIMEOUT_EN` undefined:
  - WAIT lasts indefinitely.
  - `c0_err`/`c1_err` are tied to 0 and no counter is built.

## Test plan
- Reset, then c0 write: addr=0x123, wdata=0xA5. Required response:
  - c0_gnt and eng_wr pulse in cycle 1, with eng_addr=0x123 and eng_wdata=0xA5.
  - After ack, c0_done=1, c0_err=0, rd_data=0x00.
- c1 read, addr=0x7FF, engine returns 0x3C with ack. Required response: eng_rd pulses once, then c1_done=1 with rd_data=0x3C.
- c0 and c1 request simultaneously and hold req. Required response: grants go c0, c1, c0, c1; no client gets two consecutive grants.
- Ack pulse during ISSUE and during IDLE. Required response: ignored; no done; the FSM still waits for the ack in WAIT.
- With `EEPROM_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=16, no ack. Required response:
  - done and err both pulse after the count reaches 16, and rd_data keeps its prior value.
  - Repeat with ack on the 16th WAIT cycle: err=0.
- RESET asserted during WAIT of a c1 read. Required response:
  - The next cycle shows all outputs at 0 and state IDLE, and no c1_done.
  - A subsequent simultaneous request grants c0.
